// File: rtl/adc_capture_meas.sv
// ADC receive path: divides sys_clk into the ADC sample clock, captures 8-bit samples and
// publishes max/min/peak-to-peak/rising-crossing statistics once per fixed sample window.
module adc_capture_meas #(
  parameter int CLK_DIV     = 4,
  parameter int WIN_SAMPLES = 4096,
  parameter int HYST        = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  ad_data,
  output logic        ad_clk,
  output logic [7:0]  vmax,
  output logic [7:0]  vmin,
  output logic [7:0]  vpp,
  output logic [15:0] cross_cnt,
  output logic        meas_valid
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(WIN_SAMPLES);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [CW-1:0] WIN_LAST = CW'(WIN_SAMPLES - 1);
  localparam logic [8:0]    HYST9    = 9'(HYST);

  typedef enum logic {ACQ, PUB} state_t;

  state_t        state_q;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          ad_clk_q;
  logic          smp_en_q;
  logic [7:0]    sample_q;
  logic [CW-1:0] win_cnt_q;
  logic [7:0]    run_max_q, run_max_d;
  logic [7:0]    run_min_q, run_min_d;
  logic [15:0]   run_cross_q, run_cross_d;
  logic          armed_q, armed_d;
  logic [7:0]    thr_q, thr_d;
  logic [8:0]    lo9, hi9, thr_sum9;
  logic [7:0]    vmax_q, vmin_q, vpp_q;
  logic [15:0]   cross_cnt_q;
  logic          meas_valid_q;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    run_max_d = (sample_q > run_max_q) ? sample_q : run_max_q;
    run_min_d = (sample_q < run_min_q) ? sample_q : run_min_q;
    // Hysteresis band around the threshold, saturating at both rails.
    lo9 = ({1'b0, thr_q} >= HYST9) ? {1'b0, thr_q} - HYST9 : 9'd0;
    hi9 = ({1'b0, thr_q} + HYST9 > 9'd255) ? 9'd255 : {1'b0, thr_q} + HYST9;
    armed_d     = armed_q;
    run_cross_d = run_cross_q;
    if ({1'b0, sample_q} < lo9) begin
      armed_d = 1'b1;
    end else if (armed_q && ({1'b0, sample_q} >= hi9)) begin
      armed_d = 1'b0;
      if (run_cross_q != 16'hFFFF) run_cross_d = run_cross_q + 16'd1;
    end
    thr_sum9 = {1'b0, run_max_d} + {1'b0, run_min_d} + 9'd1;
    thr_d    = thr_sum9[8:1];
  end

  // The sample captured at the end of the ad_clk high phase is processed one cycle later;
  // the final sample of a window loads the published registers on that same edge.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q      <= ACQ;
      div_cnt_q    <= '0;
      ad_clk_q     <= 1'b0;
      smp_en_q     <= 1'b0;
      sample_q     <= 8'd0;
      win_cnt_q    <= '0;
      run_max_q    <= 8'd0;
      run_min_q    <= 8'd255;
      run_cross_q  <= 16'd0;
      armed_q      <= 1'b0;
      thr_q        <= 8'd128;
      vmax_q       <= 8'd0;
      vmin_q       <= 8'd0;
      vpp_q        <= 8'd0;
      cross_cnt_q  <= 16'd0;
      meas_valid_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      ad_clk_q     <= (div_cnt_d >= DIV_HALF);
      smp_en_q     <= (div_cnt_q == DIV_LAST);
      if (div_cnt_q == DIV_LAST) sample_q <= ad_data;
      meas_valid_q <= 1'b0;
      case (state_q)
        ACQ: begin
          if (smp_en_q) begin
            armed_q <= armed_d;
            if (win_cnt_q == WIN_LAST) begin
              vmax_q       <= run_max_d;
              vmin_q       <= run_min_d;
              vpp_q        <= run_max_d - run_min_d;
              cross_cnt_q  <= run_cross_d;
              meas_valid_q <= 1'b1;
              thr_q        <= thr_d;
              run_max_q    <= 8'd0;
              run_min_q    <= 8'd255;
              run_cross_q  <= 16'd0;
              win_cnt_q    <= '0;
              state_q      <= PUB;
            end else begin
              run_max_q   <= run_max_d;
              run_min_q   <= run_min_d;
              run_cross_q <= run_cross_d;
              win_cnt_q   <= win_cnt_q + 1'b1;
            end
          end
        end
        PUB: state_q <= ACQ;
        default: state_q <= ACQ;
      endcase
    end
  end

  assign ad_clk     = ad_clk_q;
  assign vmax       = vmax_q;
  assign vmin       = vmin_q;
  assign vpp        = vpp_q;
  assign cross_cnt  = cross_cnt_q;
  assign meas_valid = meas_valid_q;

endmodule

// File: tb/tb_adc_capture_meas.sv
// Bench for adc_capture_meas: directed waveforms per window, expected window results
// queued by the driver and compared by an independent meas_valid monitor.
module tb_adc_capture_meas;
  localparam int CLK_DIV = 4;
  localparam int WIN     = 256;
  localparam int HYST    = 4;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  ad_data   = 8'd0;
  logic        ad_clk;
  logic [7:0]  vmax, vmin, vpp;
  logic [15:0] cross_cnt;
  logic        meas_valid;

  adc_capture_meas #(.CLK_DIV(CLK_DIV), .WIN_SAMPLES(WIN), .HYST(HYST)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .ad_data   (ad_data),
    .ad_clk    (ad_clk),
    .vmax      (vmax),
    .vmin      (vmin),
    .vpp       (vpp),
    .cross_cnt (cross_cnt),
    .meas_valid(meas_valid)
  );

  // clock / reset-relative cycle counter
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) begin
    if (!sys_rst_n) cyc = 0;
    else            cyc = cyc + 1;
  end

  int          checks  = 0;
  int          errors  = 0;
  int          win_idx = 0;
  logic [39:0] exp_q[$];
  int          exp_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive_sample(input logic [7:0] v);
    ad_data = v;
    for (int j = 1; j <= CLK_DIV; j++) begin
      @(negedge sys_clk);
      check("ad_clk", {31'd0, ad_clk}, {31'd0, (j % CLK_DIV) >= CLK_DIV / 2});
    end
  endtask

  task automatic expect_win(input logic [7:0] emax, input logic [7:0] emin,
                            input logic [7:0] epp, input logic [15:0] ecross);
    exp_q.push_back({emax, emin, epp, ecross});
    exp_cyc_q.push_back((win_idx + 1) * CLK_DIV * WIN + 1);
    win_idx++;
  endtask

  task automatic do_reset(input int n);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (n) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    win_idx   = 0;
  endtask

  task automatic idle();
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_vmax"}, {24'd0, vmax}, 32'd0);
    check({tag, "_vmin"}, {24'd0, vmin}, 32'd0);
    check({tag, "_vpp"}, {24'd0, vpp}, 32'd0);
    check({tag, "_cross"}, {16'd0, cross_cnt}, 32'd0);
    check({tag, "_valid"}, {31'd0, meas_valid}, 32'd0);
  endtask

  // scoreboard monitor
  logic prev_valid = 1'b0;
  always @(negedge sys_clk) begin
    logic [39:0] e;
    int          c;
    if (meas_valid) begin
      check("valid_pulse_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_meas_valid: got vmax=%0d vmin=%0d cross=%0d expected none",
                 vmax, vmin, cross_cnt);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("vmax", {24'd0, vmax}, {24'd0, e[39:32]});
        check("vmin", {24'd0, vmin}, {24'd0, e[31:24]});
        check("vpp", {24'd0, vpp}, {24'd0, e[23:16]});
        check("cross_cnt", {16'd0, cross_cnt}, {16'd0, e[15:0]});
        check("valid_latency", cyc, c);
      end
    end
    prev_valid = meas_valid;
  end

  initial begin
    // reset state
    sys_rst_n = 1'b0;
    ad_data   = 8'd100;
    repeat (10) @(negedge sys_clk);
    check("rst_ad_clk", {31'd0, ad_clk}, 32'd0);
    check_outputs_clear("rst");
    sys_rst_n = 1'b1;
    win_idx   = 0;

    // constant input: second window uses thr=100, band 96..104
    expect_win(8'd100, 8'd100, 8'd0, 16'd0);
    expect_win(8'd100, 8'd100, 8'd0, 16'd0);
    repeat (2 * WIN) drive_sample(8'd100);
    idle();

    // sawtooth: one full ramp per window, one crossing each
    do_reset(2);
    expect_win(8'd255, 8'd0, 8'd255, 16'd1);
    expect_win(8'd255, 8'd0, 8'd255, 16'd1);
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < WIN; i++) drive_sample(8'(i));
    idle();

    // square wave 50/200 every 32 samples; second window runs with thr=125
    do_reset(2);
    expect_win(8'd200, 8'd50, 8'd150, 16'd4);
    expect_win(8'd200, 8'd50, 8'd150, 16'd4);
    for (int i = 0; i < 2 * WIN; i++) drive_sample(((i / 32) % 2) ? 8'd200 : 8'd50);
    idle();

    // hysteresis: 127/130 never leaves the 124..132 band
    do_reset(2);
    expect_win(8'd130, 8'd127, 8'd3, 16'd0);
    for (int i = 0; i < WIN; i++) drive_sample((i % 2) ? 8'd130 : 8'd127);
    idle();

    // 120/135: every rising step crosses, including the window's last sample
    do_reset(2);
    expect_win(8'd135, 8'd120, 8'd15, 16'd128);
    for (int i = 0; i < WIN; i++) drive_sample((i % 2) ? 8'd135 : 8'd120);
    idle();
    check("hold_cross", {16'd0, cross_cnt}, 32'd128);

    // reset mid-window discards the partial window and clears outputs
    for (int i = 0; i < 100; i++) drive_sample(((i / 32) % 2) ? 8'd200 : 8'd50);
    do_reset(1);
    check_outputs_clear("midrst");
    expect_win(8'd200, 8'd50, 8'd150, 16'd4);
    for (int i = 0; i < WIN; i++) drive_sample(((i / 32) % 2) ? 8'd200 : 8'd50);
    idle();
    check("hold_vmax", {24'd0, vmax}, 32'd200);
    check("hold_vmin", {24'd0, vmin}, 32'd50);

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge sys_clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending windows expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
